// File: rtl/taillight_decoder.sv
// Thunderbird taillight observer: classifies each lamp update per side, decodes turn/hazard/brake, flags faults.
// Registered outputs, 1 cycle after a tick sample; no backpressure, state advances only on tick.

module taillight_side #(
    parameter int TURN_STEPS = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_tick,
    input  logic [2:0] i_lamps,
    output logic       o_seq_nxt,
    output logic       o_hold_nxt,
    output logic       o_illegal,
    output logic       o_sweep
);
    localparam logic [1:0] STEPS = TURN_STEPS[1:0];

    logic [2:0] r_prev;
    logic [1:0] r_cnt;
    logic [1:0] w_cnt_nxt;
    logic       w_inc;

    function automatic logic is_legal(input logic [2:0] p);
        return (p == 3'b000) || (p == 3'b001) || (p == 3'b011) || (p == 3'b111);
    endfunction

    always_comb begin
        w_inc     = 1'b0;
        o_illegal = 1'b0;
        if (!is_legal(r_prev) || !is_legal(i_lamps)) begin
            o_illegal = 1'b1;
        end else begin
            case ({r_prev, i_lamps})
                6'b000_001, 6'b001_011, 6'b011_111: w_inc = 1'b1;
                // 111->000 continues a sweep only if one is already running
                6'b111_000: w_inc = (r_cnt != 2'd0);
                6'b000_000, 6'b001_000, 6'b011_000,
                6'b000_111, 6'b001_111, 6'b111_111: w_inc = 1'b0;
                default: o_illegal = 1'b1;
            endcase
        end
        if (w_inc) w_cnt_nxt = (r_cnt == 2'd3) ? 2'd3 : r_cnt + 2'd1;
        else       w_cnt_nxt = 2'd0;
    end

    assign o_seq_nxt  = (w_cnt_nxt >= STEPS);
    assign o_hold_nxt = (r_prev == 3'b111) && (i_lamps == 3'b111);
    assign o_sweep    = ({r_prev, i_lamps} == 6'b011_111);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev <= 3'b000;
            r_cnt  <= 2'd0;
        end else if (i_tick) begin
            r_prev <= i_lamps;
            r_cnt  <= w_cnt_nxt;
        end
    end
endmodule

module taillight_decoder #(
    parameter int TURN_STEPS = 2,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick,
    input  logic [2:0]       left_lamps,
    input  logic [2:0]       right_lamps,
    output logic             left_turn,
    output logic             right_turn,
    output logic             hazard,
    output logic             brake,
    output logic             fault_left,
    output logic             fault_right,
    output logic [CNT_W-1:0] blink_count
);
    logic w_l_seq, w_l_hold, w_l_ill, w_l_sweep;
    logic w_r_seq, w_r_hold, w_r_ill, w_r_sweep;
    logic w_both, w_eq, w_blink;

    taillight_side #(.TURN_STEPS(TURN_STEPS)) u_left (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_tick    (tick),
        .i_lamps   (left_lamps),
        .o_seq_nxt (w_l_seq),
        .o_hold_nxt(w_l_hold),
        .o_illegal (w_l_ill),
        .o_sweep   (w_l_sweep)
    );

    taillight_side #(.TURN_STEPS(TURN_STEPS)) u_right (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_tick    (tick),
        .i_lamps   (right_lamps),
        .o_seq_nxt (w_r_seq),
        .o_hold_nxt(w_r_hold),
        .o_illegal (w_r_ill),
        .o_sweep   (w_r_sweep)
    );

    assign w_both  = w_l_seq && w_r_seq;
    assign w_eq    = (left_lamps == right_lamps);
    // Hazard sweeps count once: either side completing a sweep is enough
    assign w_blink = (w_l_sweep && w_l_seq) || (w_r_sweep && w_r_seq);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            left_turn   <= 1'b0;
            right_turn  <= 1'b0;
            hazard      <= 1'b0;
            brake       <= 1'b0;
            fault_left  <= 1'b0;
            fault_right <= 1'b0;
            blink_count <= '0;
        end else if (tick) begin
            left_turn   <= w_l_seq && !w_r_seq;
            right_turn  <= w_r_seq && !w_l_seq;
            hazard      <= w_both && w_eq;
            brake       <= (w_l_hold && !w_l_seq) || (w_r_hold && !w_r_seq);
            fault_left  <= fault_left  || w_l_ill || (w_both && !w_eq);
            fault_right <= fault_right || w_r_ill || (w_both && !w_eq);
            if (w_blink && (blink_count != '1))
                blink_count <= blink_count + CNT_W'(1);
        end
    end
endmodule
